// File: rtl/fireball_pkg.sv
// Shared playfield geometry, slot coordinate widths and scheduler state encoding.
// Also consumed by life_count for the x/y widths.
package fireball_pkg;

    localparam int unsigned PF_W      = 96;
    localparam int unsigned PF_H      = 64;
    localparam int unsigned SPRITE_SZ = 4;
    localparam int unsigned X_W       = 7;
    localparam int unsigned Y_W       = 6;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [X_W-1:0] PARK_X = X_W'(127);
    localparam logic [Y_W-1:0] PARK_Y = Y_W'(PF_H - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPD0,
        ST_UPD1,
        ST_UPD2,
        ST_UPD3,
        ST_SPAWN
    } state_e;

    // Fold LFSR values beyond the right edge back into the playfield.
    function automatic logic [X_W-1:0] spawn_x(input logic [X_W-1:0] l,
                                               input logic [X_W-1:0] x_max);
        return (l <= x_max) ? l : (l - X_W'(64));
    endfunction

endpackage

// File: rtl/fireball_lfsr.sv
// 7-bit Fibonacci LFSR (x^7 + x^6 + 1) that advances only when step_i is high.
module fireball_lfsr
    import fireball_pkg::*;
#(
    parameter logic [X_W-1:0] SEED = 7'h5A
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           step_i,
    output logic [X_W-1:0] l_o
);

    logic [X_W-1:0] l_q;
    logic [X_W-1:0] l_d;

    always_comb begin
        l_d = l_q;
        if (step_i) begin
            l_d = {l_q[X_W-2:0], l_q[X_W-1] ^ l_q[X_W-2]};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            l_q <= SEED;
        end else begin
            l_q <= l_d;
        end
    end

    assign l_o = l_q;

endmodule

// File: rtl/fireball_sched.sv
// Fireball slot scheduler: one slot update per clock per tick, then a spawn attempt.
// Build option FIREBALL_SPEEDUP_EN shortens the spawn period every 8 spawns (floor 4).
module fireball_sched
    import fireball_pkg::*;
#(
    parameter int unsigned    SPAWN_PERIOD = 16,
    parameter int unsigned    SPEED        = 1,
    parameter int unsigned    Y_LIMIT      = 60,
    parameter int unsigned    X_MAX        = PF_W - SPRITE_SZ,
    parameter logic [X_W-1:0] LFSR_SEED    = 7'h5A
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 tick,
    input  logic                 freeze,
    output logic [X_W-1:0]       fire1_x,
    output logic [X_W-1:0]       fire2_x,
    output logic [X_W-1:0]       fire3_x,
    output logic [X_W-1:0]       fire4_x,
    output logic [Y_W-1:0]       fire1_y,
    output logic [Y_W-1:0]       fire2_y,
    output logic [Y_W-1:0]       fire3_y,
    output logic [Y_W-1:0]       fire4_y,
    output logic [NUM_SLOTS-1:0] active,
    output logic                 busy,
    output logic                 overrun
);

    state_e                            state_q, state_d;
    logic [NUM_SLOTS-1:0][X_W-1:0]     x_q, x_d;
    logic [NUM_SLOTS-1:0][Y_W-1:0]     y_q, y_d;
    logic [NUM_SLOTS-1:0]              act_q, act_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              ovr_q, ovr_d;
    logic                              busy_q;
    logic [CNT_W-1:0]                  period;
    logic                              tick_ok;
    logic                              lfsr_step;
    logic [X_W-1:0]                    lfsr_l;
    logic                              upd_en;
    logic [1:0]                        upd_idx;
    logic [Y_W:0]                      ny;
    logic                              free_any;
    logic [1:0]                        free_idx;

`ifdef FIREBALL_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_FLOOR = CNT_W'(4);
    logic [2:0]       nspawn_q, nspawn_d;
    logic [CNT_W-1:0] per_q, per_d;
    assign period = per_q;
`else
    assign period = CNT_W'(SPAWN_PERIOD);
`endif

    fireball_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .clr_n  (clr_n),
        .step_i (lfsr_step),
        .l_o    (lfsr_l)
    );

    assign tick_ok = tick & ~freeze;

    // Which slot the current UPD state owns.
    always_comb begin
        upd_en  = 1'b1;
        upd_idx = 2'd0;
        case (state_q)
            ST_UPD0: upd_idx = 2'd0;
            ST_UPD1: upd_idx = 2'd1;
            ST_UPD2: upd_idx = 2'd2;
            ST_UPD3: upd_idx = 2'd3;
            default: upd_en  = 1'b0;
        endcase
    end

    // One extra bit so y + SPEED past the bottom cannot wrap back on screen.
    assign ny = {1'b0, y_q[upd_idx]} + (Y_W+1)'(SPEED);

    // Lowest-index free slot.
    always_comb begin
        free_any = ~&act_q;
        free_idx = 2'd0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        act_d     = act_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        lfsr_step = 1'b0;
`ifdef FIREBALL_SPEEDUP_EN
        nspawn_d  = nspawn_q;
        per_d     = per_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tick_ok) begin
                    state_d = ST_UPD0;
                    if (cnt_q < period) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_UPD0: state_d = ST_UPD1;
            ST_UPD1: state_d = ST_UPD2;
            ST_UPD2: state_d = ST_UPD3;
            ST_UPD3: state_d = ST_SPAWN;
            ST_SPAWN: begin
                state_d = ST_IDLE;
                // Without a free slot the counter stays saturated: spawn remains pending.
                if ((cnt_q == period) && free_any) begin
                    act_d[free_idx] = 1'b1;
                    x_d[free_idx]   = spawn_x(lfsr_l, X_W'(X_MAX));
                    y_d[free_idx]   = '0;
                    cnt_d           = '0;
                    lfsr_step       = 1'b1;
`ifdef FIREBALL_SPEEDUP_EN
                    nspawn_d = nspawn_q + 3'd1;
                    if ((nspawn_q == 3'd7) && (per_q > PERIOD_FLOOR)) begin
                        per_d = per_q - CNT_W'(1);
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (upd_en && act_q[upd_idx]) begin
            if (ny > (Y_W+1)'(Y_LIMIT)) begin
                act_d[upd_idx] = 1'b0;
                x_d[upd_idx]   = PARK_X;
                y_d[upd_idx]   = PARK_Y;
            end else begin
                y_d[upd_idx]   = ny[Y_W-1:0];
            end
        end

        if (tick_ok && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            x_q      <= {NUM_SLOTS{PARK_X}};
            y_q      <= {NUM_SLOTS{PARK_Y}};
            act_q    <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FIREBALL_SPEEDUP_EN
            nspawn_q <= '0;
            per_q    <= CNT_W'(SPAWN_PERIOD);
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            busy_q   <= (state_d != ST_IDLE);
`ifdef FIREBALL_SPEEDUP_EN
            nspawn_q <= nspawn_d;
            per_q    <= per_d;
`endif
        end
    end

    assign fire1_x = x_q[0];
    assign fire2_x = x_q[1];
    assign fire3_x = x_q[2];
    assign fire4_x = x_q[3];
    assign fire1_y = y_q[0];
    assign fire2_y = y_q[1];
    assign fire3_y = y_q[2];
    assign fire4_y = y_q[3];
    assign active  = act_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_fireball_sched.sv
// Scoreboard bench for fireball_sched: a default instance and a fast-spawn instance
// (SPAWN_PERIOD=4, so all four slots fill up) share the same stimulus.
module tb_fireball_sched;

    typedef struct packed {
        logic [3:0]  act;
        logic [27:0] xs;
        logic [23:0] ys;
    } snap_t;

    typedef struct packed {
        snap_t s0;
        snap_t s1;
    } pair_t;

    logic clk    = 1'b0;
    logic clr_n  = 1'b0;
    logic tick   = 1'b0;
    logic freeze = 1'b0;

    logic [6:0] m_x1, m_x2, m_x3, m_x4, f_x1, f_x2, f_x3, f_x4;
    logic [5:0] m_y1, m_y2, m_y3, m_y4, f_y1, f_y2, f_y3, f_y4;
    logic [3:0] m_act, f_act;
    logic       m_busy, f_busy, m_ovr, f_ovr;

    wire [27:0] m_xs = {m_x4, m_x3, m_x2, m_x1};
    wire [23:0] m_ys = {m_y4, m_y3, m_y2, m_y1};
    wire [27:0] f_xs = {f_x4, f_x3, f_x2, f_x1};
    wire [23:0] f_ys = {f_y4, f_y3, f_y2, f_y1};

    int n_checks = 0;
    int n_fail   = 0;
    int tick_n   = 0;

    pair_t sb_q[$];

    // Reference model, index 0 = default instance, 1 = fast instance.
    int         cfg_per[2];
    logic [6:0] mx[2][4];
    logic [5:0] my[2][4];
    logic [3:0] mact[2];
    int         mcnt[2];
    int         mper[2];
    logic [6:0] mlfsr[2];
`ifdef FIREBALL_SPEEDUP_EN
    int         mnsp[2];
`endif

    always #5 clk = ~clk;

    fireball_sched u_main (
        .clk(clk), .clr_n(clr_n), .tick(tick), .freeze(freeze),
        .fire1_x(m_x1), .fire2_x(m_x2), .fire3_x(m_x3), .fire4_x(m_x4),
        .fire1_y(m_y1), .fire2_y(m_y2), .fire3_y(m_y3), .fire4_y(m_y4),
        .active(m_act), .busy(m_busy), .overrun(m_ovr)
    );

    fireball_sched #(.SPAWN_PERIOD(4)) u_fast (
        .clk(clk), .clr_n(clr_n), .tick(tick), .freeze(freeze),
        .fire1_x(f_x1), .fire2_x(f_x2), .fire3_x(f_x3), .fire4_x(f_x4),
        .fire1_y(f_y1), .fire2_y(f_y2), .fire3_y(f_y3), .fire4_y(f_y4),
        .active(f_act), .busy(f_busy), .overrun(f_ovr)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mact[k]  = 4'b0000;
            mcnt[k]  = 0;
            mper[k]  = cfg_per[k];
            mlfsr[k] = 7'h5A;
`ifdef FIREBALL_SPEEDUP_EN
            mnsp[k]  = 0;
`endif
            for (int i = 0; i < 4; i++) begin
                mx[k][i] = 7'd127;
                my[k][i] = 6'd63;
            end
        end
    endtask

    // Whole pass at once: count, move all active slots, then try to spawn.
    task automatic model_pass(input int k);
        int ny;
        int fi;
        if (mcnt[k] < mper[k]) mcnt[k]++;
        for (int i = 0; i < 4; i++) begin
            if (mact[k][i]) begin
                ny = int'(my[k][i]) + 1;
                if (ny > 60) begin
                    mact[k][i] = 1'b0;
                    mx[k][i]   = 7'd127;
                    my[k][i]   = 6'd63;
                end else begin
                    my[k][i] = 6'(ny);
                end
            end
        end
        if (mcnt[k] == mper[k]) begin
            fi = -1;
            for (int i = 3; i >= 0; i--) if (!mact[k][i]) fi = i;
            if (fi >= 0) begin
                mact[k][fi] = 1'b1;
                mx[k][fi]   = (mlfsr[k] > 7'd92) ? (mlfsr[k] - 7'd64) : mlfsr[k];
                my[k][fi]   = 6'd0;
                mcnt[k]     = 0;
                mlfsr[k]    = {mlfsr[k][5:0], mlfsr[k][6] ^ mlfsr[k][5]};
`ifdef FIREBALL_SPEEDUP_EN
                mnsp[k]++;
                if ((mnsp[k] % 8 == 0) && (mper[k] > 4)) mper[k]--;
`endif
            end
        end
    endtask

    function automatic snap_t model_snap(input int k);
        snap_t s;
        s.act = mact[k];
        s.xs  = {mx[k][3], mx[k][2], mx[k][1], mx[k][0]};
        s.ys  = {my[k][3], my[k][2], my[k][1], my[k][0]};
        return s;
    endfunction

    // One-cycle tick; an accepted tick pushes the expected post-pass state.
    task automatic pulse_tick();
        pair_t p;
        @(negedge clk);
        tick = 1'b1;
        if (!freeze) begin
            model_pass(0);
            model_pass(1);
            p.s0 = model_snap(0);
            p.s1 = model_snap(1);
            sb_q.push_back(p);
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Wait for the pass to finish, then pop the scoreboard and compare.
    task automatic wait_pass(input string tag);
        pair_t e;
        bit    done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (!m_busy && !f_busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: busy=%b/%b, want 0", tag, m_busy, f_busy);
        end else if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s scoreboard: no expected entry for completed pass", tag);
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (m_act !== e.s0.act) begin n_fail++; $display("FAIL %s main active: got %b want %b", tag, m_act, e.s0.act); end
            n_checks++;
            if (m_xs !== e.s0.xs) begin n_fail++; $display("FAIL %s main x: got %h want %h", tag, m_xs, e.s0.xs); end
            n_checks++;
            if (m_ys !== e.s0.ys) begin n_fail++; $display("FAIL %s main y: got %h want %h", tag, m_ys, e.s0.ys); end
            n_checks++;
            if (f_act !== e.s1.act) begin n_fail++; $display("FAIL %s fast active: got %b want %b", tag, f_act, e.s1.act); end
            n_checks++;
            if (f_xs !== e.s1.xs) begin n_fail++; $display("FAIL %s fast x: got %h want %h", tag, f_xs, e.s1.xs); end
            n_checks++;
            if (f_ys !== e.s1.ys) begin n_fail++; $display("FAIL %s fast y: got %h want %h", tag, f_ys, e.s1.ys); end
        end
    endtask

    task automatic do_tick(input string tag);
        pulse_tick();
        tick_n++;
        wait_pass(tag);
    endtask

    task automatic test_reset();
        logic [27:0] park_xs;
        logic [23:0] park_ys;
        park_xs = {4{7'd127}};
        park_ys = {4{6'd63}};
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (m_act !== 4'b0000) begin n_fail++; $display("FAIL reset active: got %b want 0000", m_act); end
        n_checks++; if (m_xs !== park_xs) begin n_fail++; $display("FAIL reset x: got %h want %h", m_xs, park_xs); end
        n_checks++; if (m_ys !== park_ys) begin n_fail++; $display("FAIL reset y: got %h want %h", m_ys, park_ys); end
        n_checks++; if (m_busy !== 1'b0 || m_ovr !== 1'b0) begin n_fail++; $display("FAIL reset busy/overrun: got %b/%b want 0/0", m_busy, m_ovr); end
        n_checks++; if (f_act !== 4'b0000) begin n_fail++; $display("FAIL reset fast active: got %b want 0000", f_act); end
    endtask

    task automatic test_first_spawn();
        repeat (15) do_tick("pre_spawn");
        n_checks++; if (m_act !== 4'b0000) begin n_fail++; $display("FAIL tick15 active: got %b want 0000", m_act); end
        do_tick("spawn1");
        n_checks++; if (m_act !== 4'b0001) begin n_fail++; $display("FAIL spawn1 active: got %b want 0001", m_act); end
        n_checks++; if (m_x1 !== 7'd90 || m_y1 !== 6'd0) begin n_fail++; $display("FAIL spawn1 pos: got %0d,%0d want 90,0", m_x1, m_y1); end
        n_checks++; if (f_act !== 4'b1111) begin n_fail++; $display("FAIL fast full: got %b want 1111", f_act); end
        repeat (16) do_tick("run2");
        n_checks++; if (m_y1 !== 6'd16) begin n_fail++; $display("FAIL slot1 y after 16: got %0d want 16", m_y1); end
        n_checks++; if (m_x2 !== 7'd53 || m_act !== 4'b0011) begin n_fail++; $display("FAIL spawn2: got x=%0d act=%b want 53 0011", m_x2, m_act); end
    endtask

    // Busy window and slot-1 visibility relative to the sampled tick.
    task automatic test_latency();
        int busy_cnt = 0;
        pulse_tick();
        tick_n++;
        n_checks++; if (m_y1 !== 6'd16) begin n_fail++; $display("FAIL latency y at T+1: got %0d want 16", m_y1); end
        if (m_busy) busy_cnt++;
        @(negedge clk);
        n_checks++; if (m_y1 !== 6'd17) begin n_fail++; $display("FAIL latency y at T+2: got %0d want 17", m_y1); end
        if (m_busy) busy_cnt++;
        repeat (3) begin @(negedge clk); if (m_busy) busy_cnt++; end
        @(negedge clk);
        n_checks++; if (m_busy !== 1'b0 || busy_cnt != 5) begin n_fail++; $display("FAIL latency busy: T+6=%b cycles=%0d want 0 5", m_busy, busy_cnt); end
        wait_pass("latency");
    endtask

    task automatic test_full_and_retire();
        while (tick_n < 80) begin
            do_tick("run");
            if (tick_n == 40) begin
                n_checks++; if (f_act !== 4'b1111) begin n_fail++; $display("FAIL fast pending full: got %b want 1111", f_act); end
            end
            if (tick_n == 64) begin
                n_checks++; if (f_y1 !== 6'd60 || f_act !== 4'b1111) begin n_fail++; $display("FAIL fast t64: y1=%0d act=%b want 60 1111", f_y1, f_act); end
                n_checks++; if (m_x3 !== 7'd43) begin n_fail++; $display("FAIL wrapped spawn x: got %0d want 43", m_x3); end
            end
            if (tick_n == 65) begin
                n_checks++; if (f_act !== 4'b1111 || f_y1 !== 6'd0 || f_x1 !== 7'd45) begin
                    n_fail++; $display("FAIL fast respawn: act=%b y1=%0d x1=%0d want 1111 0 45", f_act, f_y1, f_x1);
                end
            end
            if (tick_n == 77) begin
                n_checks++; if (m_act !== 4'b1110 || m_x1 !== 7'd127 || m_y1 !== 6'd63) begin
                    n_fail++; $display("FAIL retire: act=%b pos=%0d,%0d want 1110 127,63", m_act, m_x1, m_y1);
                end
            end
            if (tick_n == 80) begin
                n_checks++; if (m_act !== 4'b1111 || m_y1 !== 6'd0 || m_x1 !== 7'd45) begin
                    n_fail++; $display("FAIL reuse: act=%b pos=%0d,%0d want 1111 45,0", m_act, m_x1, m_y1);
                end
            end
        end
    endtask

    task automatic test_freeze();
        snap_t exp;
        freeze = 1'b1;
        repeat (3) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL frozen tick busy: got %b want 0", m_busy); end
        end
        exp = model_snap(0);
        n_checks++; if (m_act !== exp.act || m_ys !== exp.ys) begin n_fail++; $display("FAIL frozen state: act=%b y=%h want %b %h", m_act, m_ys, exp.act, exp.ys); end
        freeze = 1'b0;
        pulse_tick();
        tick_n++;
        freeze = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_pass("freeze_mid");
        n_checks++; if (m_ovr !== 1'b0 || f_ovr !== 1'b0) begin n_fail++; $display("FAIL frozen overrun: got %b/%b want 0/0", m_ovr, f_ovr); end
        freeze = 1'b0;
    endtask

    task automatic test_overrun();
        pulse_tick();
        tick_n++;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n_checks++; if (m_ovr !== 1'b1 || f_ovr !== 1'b1) begin n_fail++; $display("FAIL overrun set: got %b/%b want 1/1", m_ovr, f_ovr); end
        wait_pass("overrun");
        do_tick("post_overrun");
        n_checks++; if (m_ovr !== 1'b1) begin n_fail++; $display("FAIL overrun sticky: got %b want 1", m_ovr); end
    endtask

    task automatic test_reset_mid_pass();
        pulse_tick();
        @(negedge clk);
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        n_checks++; if (m_act !== 4'b0000 || f_act !== 4'b0000) begin n_fail++; $display("FAIL midreset active: got %b/%b want 0000", m_act, f_act); end
        n_checks++; if (m_busy !== 1'b0 || m_ovr !== 1'b0 || m_x1 !== 7'd127 || m_y3 !== 6'd63) begin
            n_fail++; $display("FAIL midreset state: busy=%b ovr=%b x1=%0d y3=%0d want 0 0 127 63", m_busy, m_ovr, m_x1, m_y3);
        end
        sb_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (15) do_tick("after_reset");
        n_checks++; if (m_act !== 4'b0000) begin n_fail++; $display("FAIL after reset tick15 active: got %b want 0000", m_act); end
        do_tick("after_reset_spawn");
        n_checks++; if (m_act !== 4'b0001 || m_x1 !== 7'd90) begin n_fail++; $display("FAIL after reset spawn: act=%b x1=%0d want 0001 90", m_act, m_x1); end
    endtask

    initial begin
        cfg_per[0] = 16;
        cfg_per[1] = 4;
        model_reset();
        test_reset();
        test_first_spawn();
        test_latency();
        test_full_and_retire();
        test_freeze();
        test_overrun();
        test_reset_mid_pass();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fireball_sched.md
Name: fireball_sched

Overview:
- Owns the four fireball slots consumed by the collision/life logic: spawns new fireballs at pseudo-random x at the top of the 96x64 playfield, advances every active fireball downward once per game tick, and retires fireballs leaving the screen.
- Parks inactive slots off-screen so collision checks never match them.
- Sequences slot updates one per clock through a small FSM.

Parameters:
- SPAWN_PERIOD, 16, accepted ticks between spawn attempts (2..63).
- SPEED, 1, pixels added to y per tick (1..7).
- Y_LIMIT, 60, largest legal y; a slot whose new y would exceed this is retired.
- X_MAX, 92, largest legal spawn x (playfield width minus sprite width 4).
- LFSR_SEED, 7'h5A, LFSR reset value (non-zero).

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- tick  in  1  game tick strobe, 1-cycle pulse.
- freeze  in  1  pause/game-over; ticks ignored while high.
- fire1_x..fire4_x  out  7 each  slot x positions.
- fire1_y..fire4_y  out  6 each  slot y positions.
- active  out  4  per-slot active flags; bit 0 = slot 1.
- busy  out  1  high whenever FSM not in IDLE.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset (clr_n low, async): all slots inactive and parked at x=127, y=63; active=0; busy=0; overrun=0; tick counter=0; LFSR=LFSR_SEED; FSM=IDLE.
- Park rule: any inactive slot outputs x=127, y=63 every cycle.
- FSM states: IDLE, UPD0, UPD1, UPD2, UPD3, SPAWN.
- IDLE: when tick=1 and freeze=0, go to UPD0 and increment tick counter (6-bit, saturates at SPAWN_PERIOD). Otherwise stay in IDLE.
- Ticks with freeze=1 are ignored in every state: no count, no overrun.
- UPDk: if slot k is active, compute ny = y + SPEED in 7 bits. If ny > Y_LIMIT, the slot is retired (active cleared, parked); else y <= ny[5:0]. Inactive slots are untouched. Advance to the next state.
- SPAWN: a spawn happens if the counter == SPAWN_PERIOD and any slot is free.
  - The lowest-index free slot is set active, x <= sx, y <= 0.
  - Counter cleared; LFSR advances one step.
  - If no slot is free, the counter stays at SPAWN_PERIOD (spawn pending) and the LFSR holds.
  - Always return to IDLE.
- Spawn x: sx = L if L <= X_MAX, else L - 64, where L = LFSR value.
- LFSR: 7-bit Fibonacci, x^7+x^6+1. Next = {L[5:0], L[6]^L[5]}.
- Latency: tick sampled in cycle T. Slot k is updated in cycle T+1+k and is visible on outputs in cycle T+2+k. Spawn is visible at T+6. busy is high from T+1 through T+5.
- Order within one pass: moves happen before the spawn. A slot retired in this pass may be reused by this pass's spawn. A newly spawned slot is not moved until the next tick.
- Tick while busy (freeze=0): the tick is dropped and overrun is set. overrun clears only on reset.
- freeze asserted mid-pass: the pass completes normally; freeze only gates tick acceptance.

Optional Feature:
- Macro: FIREBALL_SPEEDUP_EN.
- Defined: an internal 3-bit spawn counter wraps every 8 spawns. On each wrap, the effective spawn period decrements by 1, floored at 4. The effective period resets to SPAWN_PERIOD on reset.
- Undefined: spawn period is fixed at SPAWN_PERIOD; no extra logic.

Decomposition:
- Shared package holds:
  - playfield constants: width 96, height 64, sprite size 4, park coordinates 127/63;
  - FSM state enum;
  - x/y width constants (7/6). life_count consumes the same widths.
- One natural sub-module: fireball_lfsr (7-bit LFSR with seed parameter and step enable, output L).

Test Plan:
- Reset, no ticks: active=0, all fire*_x=127, fire*_y=63, busy=0.
- 16 ticks spaced 10 cycles apart: slot 1 spawns at x=90 (0x5A), y=0, active=4'b0001. 16 more ticks: slot 1 y=16, slot 2 spawns at x=53 (LFSR 0x35).
- Single slot run to bottom: after reaching y=60, the next tick retires it (active bit 0, parks 127/63). With a spawn due in the same pass, the same slot respawns with y=0.
- All 4 slots active with a spawn due: no spawn occurs, counter holds. First retirement pass respawns into the freed slot in the same pass.
- Tick issued 2 cycles after an accepted tick: dropped, overrun=1, positions advance only once. freeze=1 with ticks: no position change and overrun unchanged.
- clr_n pulsed low mid-pass (during UPD2): immediate return to reset state; the next tick after release behaves as the first tick.
